// File: rtl/rv32_pkg.sv
// Types and constants shared by the rv32imc fetch-side blocks.
package rv32_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_entry_t;

    localparam int          FETCH_ENTRY_W   = $bits(fetch_entry_t);
    localparam logic [31:0] RV32_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/rv32_mod_fifo_sync.sv
// Synchronous FIFO with head and head+1 peek ports; clear empties it in one cycle.
module rv32_mod_fifo_sync #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         peek0,
    output logic [WIDTH-1:0]         peek1,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign rd_ptr_n = rd_ptr + AW'(1);
    assign peek0    = mem[rd_ptr];
    assign peek1    = mem[rd_ptr_n];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr_n;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv32_mod_instruction_prefetch.sv
// Instruction prefetch: word fetcher, prefetch queue and 16/32-bit realigner
// feeding the decoder one instruction at a time, with flush-based redirect.
module rv32_mod_instruction_prefetch
    import rv32_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = RV32_RESET_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic        instr_err,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data_i,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_compressed,
    output logic        out_err
);
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic                     req_q;
    logic                     discard_q;
    logic                     halt_q;
    logic [31:0]              addr_q;
    logic [31:0]              ptr_q;
    logic [31:0]              pc_q;
    logic                     resp;
    logic                     push;
    logic                     pop;
    logic                     consume;
    logic                     issue;
    logic                     halt_next;
    logic [31:0]              ptr_eff;
    logic [31:0]              pc_next;
    logic [CW:0]              occ_next;
    fetch_entry_t             push_entry;
    fetch_entry_t             head;
    fetch_entry_t             nxt;
    logic [FETCH_ENTRY_W-1:0] peek0;
    logic [FETCH_ENTRY_W-1:0] peek1;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    logic [15:0]              half_sel;
    logic                     unused_bits;

    rv32_mod_fifo_sync #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .peek0     (peek0),
        .peek1     (peek1),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head        = fetch_entry_t'(peek0);
    assign nxt         = fetch_entry_t'(peek1);
    assign unused_bits = ^{nxt.data[31:16], full};

    // Responses to a request issued before a flush are dropped on arrival.
    assign resp       = req_q && (instr_ack || instr_err);
    assign push       = resp && !discard_q && !flush;
    assign push_entry = '{data: instr_data_i, err: instr_err};

    assign instr_req  = req_q;
    assign instr_addr = addr_q;
    assign out_pc     = pc_q;

    always_comb begin
        out_valid         = 1'b0;
        out_instr         = 32'h0;
        out_is_compressed = 1'b0;
        out_err           = 1'b0;
        half_sel          = pc_q[1] ? head.data[31:16] : head.data[15:0];
        if (!empty) begin
            if (head.err) begin
                out_valid = 1'b1;
                out_err   = 1'b1;
            end else if (half_sel[1:0] != 2'b11) begin
                out_valid         = 1'b1;
                out_instr         = {16'h0, half_sel};
                out_is_compressed = 1'b1;
            end else if (!pc_q[1]) begin
                out_valid = 1'b1;
                out_instr = head.data;
            end else if (count > CW'(1)) begin
                // Upper half of the head word plus lower half of the next word.
                out_valid = 1'b1;
                out_instr = {nxt.data[15:0], half_sel};
                out_err   = nxt.err;
            end
        end
    end

    assign consume   = out_valid && out_ready && !flush;
    assign pc_next   = pc_q + (out_is_compressed ? 32'd2 : 32'd4);
    assign pop       = consume && (pc_next[31:2] != pc_q[31:2]);
    assign halt_next = !flush && (halt_q || (push && instr_err));
    assign ptr_eff   = flush ? (flush_addr & ~32'h3) : ptr_q;

    // Post-edge occupancy; the word about to be requested must still fit.
    always_comb begin
        occ_next = '0;
        if (!flush) occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    end

    assign issue = (!req_q || resp) && !halt_next && (occ_next < DEPTH_OCC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            halt_q    <= 1'b0;
            addr_q    <= RESET_ADDR & ~32'h3;
            ptr_q     <= RESET_ADDR & ~32'h3;
            pc_q      <= RESET_ADDR;
        end else begin
            halt_q <= halt_next;
            if (issue) begin
                req_q     <= 1'b1;
                addr_q    <= ptr_eff;
                ptr_q     <= ptr_eff + 32'd4;
                discard_q <= 1'b0;
            end else begin
                ptr_q <= ptr_eff;
                if (resp) begin
                    req_q     <= 1'b0;
                    discard_q <= 1'b0;
                end else if (flush && req_q) begin
                    discard_q <= 1'b1;
                end
            end
            if (flush)        pc_q <= flush_addr & ~32'h1;
            else if (consume) pc_q <= pc_next;
        end
    end

endmodule
